jk_reg_bank: RTL and testbench

- Parametrised bank of WIDTH independent JK flip-flops sharing one clock, synchronous reset, clock enable and parallel load.
- Successor to the single-bit JK element. Adds:
  - a per-bit reset pattern;
  - a registered change flag;
  - a count of bits that flipped;
  - an optional saturating change-event counter.
- Used as a status/control register bank where set/clear/toggle requests arrive as bit vectors.

---
 rtl/jk_pkg.sv | 35 +++
 rtl/jk_bit.sv | 13 +
 rtl/jk_reg_bank.sv | 89 ++++++++
 tb/tb_jk_reg_bank.sv | 133 +++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// Shared JK definitions: {j,k} operation encoding, next-state rule and popcount helper.
package jk_pkg;

    typedef enum logic [1:0] {
        HOLD   = 2'b00,
        RESET  = 2'b01,
        SET    = 2'b10,
        TOGGLE = 2'b11
    } jk_op_e;

    localparam int unsigned POP_MAX_W = 256;

    function automatic logic jk_next(input logic q, input logic j, input logic k);
        jk_op_e op;
        op = jk_op_e'({j, k});
        case (op)
            HOLD:    return q;
            RESET:   return 1'b0;
            SET:     return 1'b1;
            TOGGLE:  return ~q;
            default: return q;
        endcase
    endfunction

    // Callers zero-extend their vector to POP_MAX_W bits.
    function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < POP_MAX_W; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/jk_bit.sv
// Single JK bit: combinational next-state from the current q and the J/K request.
module jk_bit
    import jk_pkg::*;
(
    input  logic q,
    input  logic j,
    input  logic k,
    output logic q_jk
);

    assign q_jk = jk_next(q, j, k);

endmodule

// File: rtl/jk_reg_bank.sv
// Bank of WIDTH JK flip-flops with shared reset/load/enable, change flag and flip count.
// Optional saturating change-event counter enabled by `define JK_CHANGE_CNT_EN.
module jk_reg_bank
    import jk_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int unsigned      CNT_W     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       load,
    input  logic [WIDTH-1:0]           load_data,
    input  logic [WIDTH-1:0]           j,
    input  logic [WIDTH-1:0]           k,
    input  logic                       clr_cnt,
    output logic [WIDTH-1:0]           q,
    output logic                       changed,
    output logic [$clog2(WIDTH+1)-1:0] flips,
    output logic [CNT_W-1:0]           change_cnt
);

    localparam int unsigned FLIPS_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]     r_q = RESET_VAL;
    logic                 r_changed = 1'b0;
    logic [FLIPS_W-1:0]   r_flips = '0;
    logic [WIDTH-1:0]     w_jk;
    logic [WIDTH-1:0]     w_next;
    logic [WIDTH-1:0]     w_diff;
    logic [POP_MAX_W-1:0] w_diff_ext;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        jk_bit u_bit (
            .q    (r_q[gi]),
            .j    (j[gi]),
            .k    (k[gi]),
            .q_jk (w_jk[gi])
        );
    end

    always_comb begin
        w_next = r_q;
        if (load) begin
            w_next = load_data;
        end else if (en) begin
            w_next = w_jk;
        end
    end

    assign w_diff     = w_next ^ r_q;
    assign w_diff_ext = POP_MAX_W'(w_diff);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q       <= RESET_VAL;
            r_changed <= 1'b0;
            r_flips   <= '0;
        end else begin
            r_q       <= w_next;
            r_changed <= |w_diff;
            r_flips   <= FLIPS_W'(popcount(w_diff_ext));
        end
    end

`ifdef JK_CHANGE_CNT_EN
    logic [CNT_W-1:0] r_cnt = '0;

    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            r_cnt <= '0;
        end else if ((|w_diff) && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign change_cnt = r_cnt;
`else
    logic w_unused_clr_cnt;
    assign w_unused_clr_cnt = clr_cnt;
    assign change_cnt       = '0;
`endif

    assign q       = r_q;
    assign changed = r_changed;
    assign flips   = r_flips;

endmodule

// File: tb/tb_jk_reg_bank.sv
// Self-checking bench for jk_reg_bank: directed scenarios plus random stimulus against a bit-level model.
`timescale 1ns/1ps
module tb_jk_reg_bank;

    localparam int unsigned W = 8;
    localparam logic [7:0]  RV = 8'hA5;
    localparam int unsigned CW = 4;

    logic       clk = 1'b0;
    logic       rst, en, load, clr_cnt;
    logic [7:0] load_data, j, k;
    logic [7:0] q;
    logic       changed;
    logic [3:0] flips;
    logic [3:0] change_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] m_q   = RV;
    logic       m_chg = 1'b0;
    int         m_flp = 0;
    int         m_cnt = 0;

    always #5 clk = ~clk;

    jk_reg_bank #(
        .WIDTH     (W),
        .RESET_VAL (RV),
        .CNT_W     (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .load_data  (load_data),
        .j          (j),
        .k          (k),
        .clr_cnt    (clr_cnt),
        .q          (q),
        .changed    (changed),
        .flips      (flips),
        .change_cnt (change_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".q"}, 32'(q), 32'(m_q));
        check({tag, ".changed"}, 32'(changed), 32'(m_chg));
        check({tag, ".flips"}, 32'(flips), 32'(m_flp));
        check({tag, ".cnt"}, 32'(change_cnt), 32'(m_cnt));
    endtask

    // Drive one cycle, advance the reference model at the edge, then compare.
    task automatic step(input logic r, input logic l, input logic [7:0] ld, input logic e,
                        input logic [7:0] jj, input logic [7:0] kk, input logic c, input string tag);
        logic [7:0] nq;
        rst = r; load = l; load_data = ld; en = e; j = jj; k = kk; clr_cnt = c;
        @(posedge clk);
        if (r) begin
            m_q = RV; m_chg = 1'b0; m_flp = 0; m_cnt = 0;
        end else begin
            nq = m_q;
            if (l) begin
                nq = ld;
            end else if (e) begin
                for (int b = 0; b < 8; b++) begin
                    if (jj[b] && kk[b])  nq[b] = ~m_q[b];
                    else if (jj[b])      nq[b] = 1'b1;
                    else if (kk[b])      nq[b] = 1'b0;
                end
            end
            m_flp = $countones(nq ^ m_q);
            m_chg = (m_flp != 0);
            m_q   = nq;
`ifdef JK_CHANGE_CNT_EN
            if (c)                              m_cnt = 0;
            else if (m_chg && m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
`else
            m_cnt = 0;
`endif
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        rst = 0; en = 0; load = 0; clr_cnt = 0; load_data = '0; j = '0; k = '0;
        #1;
        check_all("init");

        step(1, 0, 8'h00, 0, 8'h00, 8'h00, 0, "reset");
        check("reset_q_const", 32'(q), 32'h A5);

        step(0, 0, 8'h00, 1, 8'hF0, 8'h0F, 0, "jk_set_clr");
        check("jk_q_const", 32'(q), 32'h F0);
        check("jk_flips_const", 32'(flips), 32'd4);
        step(0, 0, 8'h00, 1, 8'hFF, 8'hFF, 0, "jk_toggle");
        check("toggle_flips_const", 32'(flips), 32'd8);

        step(0, 0, 8'h00, 0, 8'hFF, 8'h00, 0, "en_hold");
        step(0, 0, 8'h00, 1, 8'h00, 8'h00, 0, "jk_hold");

        step(0, 1, 8'h3C, 1, 8'hFF, 8'hFF, 0, "load_prio");
        check("load_q_const", 32'(q), 32'h 3C);
        step(0, 1, 8'h3C, 1, 8'hFF, 8'hFF, 0, "load_same");

        for (int i = 0; i < 20; i++) step(0, 0, 8'h00, 1, 8'hFF, 8'hFF, 0, "sat");
`ifdef JK_CHANGE_CNT_EN
        check("sat_const", 32'(change_cnt), 32'h F);
`endif
        step(0, 0, 8'h00, 1, 8'hFF, 8'hFF, 1, "clr_cnt");
        step(0, 0, 8'h00, 1, 8'h01, 8'h00, 0, "after_clr");
        step(1, 1, 8'h5A, 1, 8'hFF, 8'hFF, 0, "rst_over_load");

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) == 0), 8'($urandom),
                 ($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
                 ($urandom_range(0, 15) == 0), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
